// File: rtl/router_pkg.sv
// Shared widths, FSM state encoding and header packing for the router packet source.
// The header helper is also used by the router-side testbenches.
package router_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned LEN_W  = 6;

    localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } tx_state_t;

    function automatic logic [LEN_W+ADDR_W-1:0] hdr_pack(input logic [LEN_W-1:0]  len,
                                                         input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Synchronous payload FIFO with show-ahead read data and an occupancy count.
module router_tx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers a full payload, then emits
// header, payload and parity bytes under the router's busy back-pressure.
module router_pkt_tx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_addr,
    input  logic [5:0]        req_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    output logic [DATA_W-1:0] data,
    output logic              pkt_valid,
    input  logic              busy,
    output logic              tx_done,
    output logic              cfg_err
);

    import router_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    tx_state_t               state;
    logic [ADDR_W-1:0]       addr_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        pay_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [DATA_W-1:0]       parity;
    logic [LEN_W+ADDR_W-1:0] hdr_req;
    logic [LEN_W+ADDR_W-1:0] hdr_q;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [DATA_W-1:0]       fifo_head;
    logic                    pop;
    logic                    req_fire;
    logic                    req_bad;

    assign req_ready = (state == IDLE) && !rst;
    assign pl_ready  = !fifo_full && !rst;
    assign tx_done   = (state == PARITY) && !busy && !rst;

    assign req_fire  = req_valid && req_ready;
    assign req_bad   = (req_addr == ADDR_ILLEGAL) || (req_len == '0);
    assign hdr_req   = hdr_pack(req_len, req_addr);
    assign hdr_q     = hdr_pack(len_q, addr_q);

    // A byte leaves the FIFO when it is loaded into the output register,
    // so the popped byte is the one that goes on data next.
    assign pop = !rst && !busy && !fifo_empty &&
                 ((state == HEADER) || ((state == PAYLOAD) && (pay_cnt != len_q - LEN_ONE)));

    router_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pl_valid && pl_ready),
        .wr_data (pl_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data      <= '0;
            pkt_valid <= 1'b0;
            cfg_err   <= 1'b0;
            parity    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            pay_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        if (req_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            addr_q <= req_addr;
                            len_q  <= req_len;
                            if (fifo_count >= CNT_W'(req_len)) begin
                                state     <= HEADER;
                                data      <= DATA_W'(hdr_req);
                                parity    <= DATA_W'(hdr_req);
                                pkt_valid <= 1'b1;
                            end else begin
                                state <= WAIT_DATA;
                            end
                        end
                    end
                end
                WAIT_DATA: begin
                    if (fifo_count >= CNT_W'(len_q)) begin
                        state     <= HEADER;
                        data      <= DATA_W'(hdr_q);
                        parity    <= DATA_W'(hdr_q);
                        pkt_valid <= 1'b1;
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        state   <= PAYLOAD;
                        data    <= fifo_head;
                        pay_cnt <= '0;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        parity <= parity ^ data;
                        if (pay_cnt == len_q - LEN_ONE) begin
                            state     <= PARITY;
                            data      <= parity ^ data;
                            pkt_valid <= 1'b0;
                        end else begin
                            data    <= fifo_head;
                            pay_cnt <= pay_cnt + LEN_ONE;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        data <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: per-cycle vector table plus a full-FIFO
// long-packet sequence. Each vector's inputs are held across one rising edge.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic [7:0] data;
    logic       pkt_valid;
    logic       busy;
    logic       tx_done;
    logic       cfg_err;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    always #5 clk = ~clk;

    router_pkt_tx #(
        .DATA_W     (8),
        .FIFO_DEPTH (64),
        .GAP_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .data      (data),
        .pkt_valid (pkt_valid),
        .busy      (busy),
        .tx_done   (tx_done),
        .cfg_err   (cfg_err)
    );

    typedef struct {
        logic       rst;
        logic       rv;
        logic [1:0] ra;
        logic [5:0] rl;
        logic       pv;
        logic [7:0] pd;
        logic       bz;
        logic [7:0] e_data;
        logic       e_pkv;
        logic       e_done;
        logic       e_err;
        logic       e_rrdy;
        logic       e_prdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rv, input logic [1:0] ra,
                                input logic [5:0] rl, input logic pv, input logic [7:0] pd,
                                input logic bz, input logic [7:0] ed, input logic epkv,
                                input logic edn, input logic eer, input logic errdy,
                                input logic eprdy);
        vec_t v;
        v.rst = r;  v.rv = rv; v.ra = ra; v.rl = rl; v.pv = pv; v.pd = pd; v.bz = bz;
        v.e_data = ed; v.e_pkv = epkv; v.e_done = edn; v.e_err = eer;
        v.e_rrdy = errdy; v.e_prdy = eprdy;
        return v;
    endfunction

    function automatic vec_t f_rst();
        return mk(1'b1, 1'b0, 2'd0, 6'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t f_wr(input logic [7:0] pd, input logic errdy);
        return mk(1'b0, 1'b0, 2'd0, 6'd0, 1'b1, pd, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, errdy, 1'b1);
    endfunction

    function automatic vec_t f_req(input logic [1:0] a, input logic [5:0] l, input logic [7:0] ed,
                                   input logic epkv, input logic eer, input logic errdy);
        return mk(1'b0, 1'b1, a, l, 1'b0, 8'h00, 1'b0, ed, epkv, 1'b0, eer, errdy, 1'b1);
    endfunction

    function automatic vec_t f_cyc(input logic bz, input logic [7:0] ed, input logic epkv,
                                   input logic edn, input logic errdy);
        return mk(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 8'h00, bz, ed, epkv, edn, 1'b0, errdy, 1'b1);
    endfunction

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        req_valid = v.rv;
        req_addr  = v.ra;
        req_len   = v.rl;
        pl_valid  = v.pv;
        pl_data   = v.pd;
        busy      = v.bz;
    endtask

    logic [7:0] big [64];
    logic [7:0] exp_par;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        pl_valid = 1'b0; pl_data = '0; busy = 1'b0;

        // Reset, then addr=1 len=3 with payload preloaded.
        vecs.push_back(f_rst());
        vecs.push_back(f_wr(8'hA1, 1'b1));
        vecs.push_back(f_wr(8'hB2, 1'b1));
        vecs.push_back(f_wr(8'hC3, 1'b1));
        vecs.push_back(f_req(2'd1, 6'd3, 8'h0D, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'hA1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'hB2, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'hC3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'hDD, 1'b0, 1'b1, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        // Same packet, busy held for 3 cycles while B2 is on data.
        vecs.push_back(f_wr(8'hA1, 1'b1));
        vecs.push_back(f_wr(8'hB2, 1'b1));
        vecs.push_back(f_wr(8'hC3, 1'b1));
        vecs.push_back(f_req(2'd1, 6'd3, 8'h0D, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'hA1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'hB2, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b1, 8'hB2, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b1, 8'hB2, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b1, 8'hB2, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'hC3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'hDD, 1'b0, 1'b1, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        // Illegal requests: addr=3, then len=0.
        vecs.push_back(f_req(2'd3, 6'd5, 8'h00, 1'b0, 1'b1, 1'b1));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        vecs.push_back(f_req(2'd1, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        // addr=2 len=4 with an empty FIFO; payload trickles in.
        vecs.push_back(f_req(2'd2, 6'd4, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(f_wr(8'h11, 1'b0));
        vecs.push_back(f_wr(8'h22, 1'b0));
        vecs.push_back(f_wr(8'h33, 1'b0));
        vecs.push_back(f_wr(8'h44, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h12, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h11, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h22, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h33, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h44, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h56, 1'b0, 1'b1, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        // Reset during the 2nd payload byte, then addr=0 len=1 from an empty FIFO.
        vecs.push_back(f_wr(8'h5A, 1'b1));
        vecs.push_back(f_wr(8'h6B, 1'b1));
        vecs.push_back(f_wr(8'h7C, 1'b1));
        vecs.push_back(f_req(2'd1, 6'd3, 8'h0D, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h6B, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_rst());
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        vecs.push_back(f_req(2'd0, 6'd1, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(f_wr(8'h9E, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h04, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h9E, 1'b1, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h9A, 1'b0, 1'b1, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(f_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk8($sformatf("v%0d data", i), data, vecs[i].e_data);
            chk1($sformatf("v%0d pkt_valid", i), pkt_valid, vecs[i].e_pkv);
            chk1($sformatf("v%0d tx_done", i), tx_done, vecs[i].e_done);
            chk1($sformatf("v%0d cfg_err", i), cfg_err, vecs[i].e_err);
            chk1($sformatf("v%0d req_ready", i), req_ready, vecs[i].e_rrdy);
            chk1($sformatf("v%0d pl_ready", i), pl_ready, vecs[i].e_prdy);
        end

        // Fill the FIFO completely, then send a len=63 packet from it.
        for (int i = 0; i < 64; i++) begin
            big[i] = 8'(i * 37 + 5);
        end
        exp_par = 8'hFD;
        for (int i = 0; i < 63; i++) begin
            exp_par = exp_par ^ big[i];
        end
        rst = 1'b0; req_valid = 1'b0; busy = 1'b0;
        for (int i = 0; i < 64; i++) begin
            pl_valid = 1'b1;
            pl_data  = big[i];
            @(posedge clk);
            #1;
            if (i == 62) chk1("fill pl_ready before full", pl_ready, 1'b1);
            if (i == 63) chk1("fill pl_ready at full", pl_ready, 1'b0);
        end
        pl_valid  = 1'b0;
        req_valid = 1'b1; req_addr = 2'd1; req_len = 6'd63;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk8("long header", data, 8'hFD);
        chk1("long header pkt_valid", pkt_valid, 1'b1);
        chk1("long header pl_ready", pl_ready, 1'b0);
        for (int i = 0; i < 63; i++) begin
            @(posedge clk);
            #1;
            chk8($sformatf("long payload %0d", i), data, big[i]);
            chk1($sformatf("long payload %0d pkt_valid", i), pkt_valid, 1'b1);
            if (i == 0) chk1("long pl_ready after pop", pl_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        chk8("long parity", data, exp_par);
        chk1("long parity pkt_valid", pkt_valid, 1'b0);
        chk1("long tx_done", tx_done, 1'b1);
        @(posedge clk);
        #1;
        chk1("long gap pkt_valid", pkt_valid, 1'b0);
        chk1("long gap tx_done", tx_done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
